// File: rtl/watch_display_scanner.sv
// watch_display_scanner: scans four 7-segment digits from a per-frame snapshot
// of the clock (HH:MM) or stopwatch (MM:SS). The display blinks while the alarm sounds.
// Ports: clk, rst (async active-low); the clock BCD digits; alarm_sound; sw_sel;
//   sw_min_in/sw_sec_in (binary); seg_out {g..a}; dp_out; an_out (one-hot, bit0 = right);
//   frame_done (1-cycle pulse at the end of each frame).
// Option: LEADING_ZERO_BLANK_EN blanks the segments of a zero in the leftmost digit.
module watch_display_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 4,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tens_hours_in,
  input  logic [3:0] units_hours_in,
  input  logic [2:0] tens_minutes_in,
  input  logic [3:0] units_minutes_in,
  input  logic       alarm_sound,
  input  logic       sw_sel,
  input  logic [5:0] sw_min_in,
  input  logic [5:0] sw_sec_in,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] an_out,
  output logic       frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_N = CW'(BLANK_CYC);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);
  localparam logic [BW-1:0] BLK_HALF = BW'(BLINK_FRAMES / 2);
  localparam logic INV = (SEG_ACTIVE_LOW != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;

  logic [1:0] sh_th_q;
  logic [3:0] sh_uh_q;
  logic [2:0] sh_tm_q;
  logic [3:0] sh_um_q;
  logic       sh_al_q;
  logic       sh_sel_q;
  logic [5:0] sh_min_q;
  logic [5:0] sh_sec_q;

  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] an_q, an_d;

  logic       frame_end;
  logic [3:0] dig_v;
  logic       dig_bad;
  logic [5:0] fld;
  logic       an_en;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    frame_end = (cnt_q == CNT_MAX) && (idx_q == 2'd3);
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    blink_d = blink_q;
    if (frame_end) begin
      blink_d = (blink_q == BLK_MAX) ? '0 : blink_q + BW'(1);
    end
  end

  // Digit selection from the shadow copy.
  always_comb begin
    dig_v = '0;
    dig_bad = 1'b0;
    fld = '0;
    if (!sh_sel_q) begin
      unique case (idx_q)
        2'd0: dig_v = sh_um_q;
        2'd1: dig_v = {1'b0, sh_tm_q};
        2'd2: dig_v = sh_uh_q;
        default: dig_v = {2'b00, sh_th_q};
      endcase
    end else begin
      fld = idx_q[1] ? sh_min_q : sh_sec_q;
      dig_bad = (fld > 6'd59);
      dig_v = idx_q[0] ? 4'(fld / 6'd10) : 4'(fld % 6'd10);
    end
  end

  always_comb begin
    seg_d = dig_bad ? 7'h40 : seg7(dig_v);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q == 2'd3 && !dig_bad && dig_v == 4'd0) begin
      seg_d = 7'h00;
    end
`endif
    // Anti-ghost gap at slot start; alarm blink dims the second half period.
    an_en = (cnt_q >= BLANK_N) && !(sh_al_q && (blink_q >= BLK_HALF));
    an_d = an_en ? (4'b0001 << idx_q) : 4'b0000;
    dp_d = an_en && (idx_q == 2'd2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      blink_q <= '0;
      sh_th_q <= '0;
      sh_uh_q <= '0;
      sh_tm_q <= '0;
      sh_um_q <= '0;
      sh_al_q <= 1'b0;
      sh_sel_q <= 1'b0;
      sh_min_q <= '0;
      sh_sec_q <= '0;
      seg_q <= '0;
      dp_q <= 1'b0;
      an_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      blink_q <= blink_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_q <= an_d;
      if (frame_end) begin
        sh_th_q <= tens_hours_in;
        sh_uh_q <= units_hours_in;
        sh_tm_q <= tens_minutes_in;
        sh_um_q <= units_minutes_in;
        sh_al_q <= alarm_sound;
        sh_sel_q <= sw_sel;
        sh_min_q <= sw_min_in;
        sh_sec_q <= sw_sec_in;
      end
    end
  end

  assign seg_out = seg_q ^ {7{INV}};
  assign dp_out = dp_q ^ INV;
  assign an_out = an_q ^ {4{INV}};
  assign frame_done = frame_end;

endmodule

// File: tb/tb_watch_display_scanner.sv
// tb_watch_display_scanner: directed and random frames checked against
// a frame-level reference model of the scanner.
module tb_watch_display_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] tens_hours_in = '0;
  logic [3:0] units_hours_in = '0;
  logic [2:0] tens_minutes_in = '0;
  logic [3:0] units_minutes_in = '0;
  logic       alarm_sound = 1'b0;
  logic       sw_sel = 1'b0;
  logic [5:0] sw_min_in = '0;
  logic [5:0] sw_sec_in = '0;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] an_out;
  logic       frame_done;

  watch_display_scanner #(
    .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(4), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst),
    .tens_hours_in(tens_hours_in), .units_hours_in(units_hours_in),
    .tens_minutes_in(tens_minutes_in), .units_minutes_in(units_minutes_in),
    .alarm_sound(alarm_sound), .sw_sel(sw_sel),
    .sw_min_in(sw_min_in), .sw_sec_in(sw_sec_in),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int k = 0;
  int blink = 0;
  int m_th, m_uh, m_tm, m_um, m_al, m_sel, m_min, m_sec;
  logic [6:0] seen [4];
  logic       seen_dp;
  logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h k=%0d", tag, obs, exp, k);
    end
  endtask

  task automatic model_clear();
    k = 0; blink = 0;
    m_th = 0; m_uh = 0; m_tm = 0; m_um = 0;
    m_al = 0; m_sel = 0; m_min = 0; m_sec = 0;
  endtask

  // One clock edge; outputs after edge k reflect scan position k-1.
  task automatic step();
    int p, idx, cnt, v, field;
    logic [6:0] eseg;
    logic [3:0] ean;
    logic bz;
    @(posedge clk);
    k++;
    p = (k - 1) % 32;
    idx = p / 8;
    cnt = p % 8;
    bz = 1'b0;
    v = 0;
    if (m_sel == 0) begin
      case (idx)
        0: v = m_um;
        1: v = m_tm;
        2: v = m_uh;
        default: v = m_th;
      endcase
      eseg = (v > 9) ? 7'h00 : tbl[v];
    end else begin
      field = (idx < 2) ? m_sec : m_min;
      if (field > 59) begin
        bz = 1'b1;
        eseg = 7'h40;
      end else begin
        v = (idx % 2 == 0) ? field % 10 : field / 10;
        eseg = tbl[v];
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3 && !bz && v == 0) eseg = 7'h00;
`endif
    ean = (cnt >= 2 && !(m_al != 0 && blink >= 2)) ? 4'(1 << idx) : 4'h0;
    #1;
    chk("seg", 32'(seg_out), 32'(eseg));
    chk("an", 32'(an_out), 32'(ean));
    chk("dp", 32'(dp_out), 32'((idx == 2 && ean != 0) ? 1 : 0));
    chk("frame_done", 32'(frame_done), 32'((k % 32 == 31) ? 1 : 0));
    if (cnt == 4) seen[idx] = seg_out;
    if (idx == 2 && cnt == 4) seen_dp = dp_out;
    if (p == 31) begin
      m_th = tens_hours_in; m_uh = units_hours_in;
      m_tm = tens_minutes_in; m_um = units_minutes_in;
      m_al = alarm_sound; m_sel = sw_sel;
      m_min = sw_min_in; m_sec = sw_sec_in;
      blink = (blink + 1) % 4;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Finish the current frame so new inputs are snapshotted.
  task automatic sync();
    step();
    while (k % 32 != 0) step();
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_an"}, 32'(an_out), 32'h0);
    chk({tag, "_seg"}, 32'(seg_out), 32'h0);
    chk({tag, "_dp"}, 32'(dp_out), 32'h0);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  initial begin
    model_clear();
    #12;
    check_reset_pins("rst0");
    release_rst();

    // Clock 12:34
    tens_hours_in = 2'd1; units_hours_in = 4'd2;
    tens_minutes_in = 3'd3; units_minutes_in = 4'd4;
    run(31);
    chk("first_fd", 32'(frame_done), 32'h1);
    run(1);
    run(32);
    chk("d0_1234", 32'(seen[0]), 32'h66);
    chk("d1_1234", 32'(seen[1]), 32'h4F);
    chk("d2_1234", 32'(seen[2]), 32'h5B);
    chk("dp_1234", 32'(seen_dp), 32'h1);
    chk("d3_1234", 32'(seen[3]), 32'h06);

    // Mid-frame change held until next snapshot
    run(20);
    units_minutes_in = 4'd5;
    run(12);
    chk("d0_hold", 32'(seen[0]), 32'h66);
    run(32);
    chk("d0_new", 32'(seen[0]), 32'h6D);

    // Stopwatch 59:07 then 59:60
    sw_sel = 1'b1; sw_min_in = 6'd59; sw_sec_in = 6'd7;
    sync();
    run(32);
    chk("sw_d3", 32'(seen[3]), 32'h6D);
    chk("sw_d2", 32'(seen[2]), 32'h6F);
    chk("sw_d1", 32'(seen[1]), 32'h3F);
    chk("sw_d0", 32'(seen[0]), 32'h07);
    sw_sec_in = 6'd60;
    sync();
    run(32);
    chk("sw_bad1", 32'(seen[1]), 32'h40);
    chk("sw_bad0", 32'(seen[0]), 32'h40);

    // Alarm blink
    sw_sel = 1'b0;
    alarm_sound = 1'b1;
    sync();
    run(32 * 8);
    alarm_sound = 1'b0;
    sync();
    run(64);

    // Leading zero, clock 05:00
    tens_hours_in = 2'd0; units_hours_in = 4'd5;
    tens_minutes_in = 3'd0; units_minutes_in = 4'd0;
    sync();
    run(32);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d3", 32'(seen[3]), 32'h00);
`else
    chk("lz_d3", 32'(seen[3]), 32'h3F);
`endif
    chk("lz_d2", 32'(seen[2]), 32'h6D);

    // Random frames, inputs changed at random points
    for (int f = 0; f < 24; f++) begin
      run($urandom_range(31, 0));
      tens_hours_in = 2'($urandom);
      units_hours_in = 4'($urandom);
      tens_minutes_in = 3'($urandom);
      units_minutes_in = 4'($urandom);
      alarm_sound = 1'($urandom_range(3, 0) == 0);
      sw_sel = 1'($urandom);
      sw_min_in = 6'($urandom_range(63, 0));
      sw_sec_in = 6'($urandom_range(63, 0));
      run($urandom_range(40, 8));
    end

    // Reset mid-slot, no clock edge needed
    run(13);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_pins("rst_mid");
    @(posedge clk);
    #1;
    check_reset_pins("rst_hold");
    release_rst();
    run(31);
    chk("fd_after_rst", 32'(frame_done), 32'h1);
    run(41);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
